// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// truth-table width helper and the legal parameter bounds.
package truth_table_sweeper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int N_IN_MIN   = 1;
  localparam int N_IN_MAX   = 8;
  localparam int SETTLE_MIN = 1;

  function automatic int tw_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper (slave side) and the harness/CUT side (master side):
// sweep request, golden table, CUT stimulus/response and sweep results.
interface truth_table_sweeper_if
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 3
);
  localparam int TW = tw_of(N_IN);

  logic            start;
  logic [TW-1:0]   expected;
  logic [N_IN-1:0] cut_in;
  logic            cut_out;
  logic            busy;
  logic            done;
  logic [TW-1:0]   table_out;
  logic [N_IN:0]   mismatch_cnt;
  logic            pass;

  modport slave (
    input  start, expected, cut_out,
    output cut_in, busy, done, table_out, mismatch_cnt, pass
  );

  modport master (
    output start, expected, cut_out,
    input  cut_in, busy, done, table_out, mismatch_cnt, pass
  );

endinterface

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Vector index plus settle counter; strobes once every SETTLE enabled cycles and
// advances the index on that strobe, flagging the last vector of the table.
module truth_table_sweeper_sweep_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            enable_i,
  output logic [N_IN-1:0] idx_o,
  output logic            sample_strobe_o,
  output logic            last_o
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  logic [N_IN-1:0] idx_q, idx_d;
  logic [SW-1:0]   settle_q, settle_d;

  assign sample_strobe_o = enable_i && (settle_q == SETTLE_LAST);
  assign last_o          = &idx_q;
  assign idx_o           = idx_q;

  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    if (clear_i) begin
      idx_d    = '0;
      settle_d = '0;
    end else if (enable_i) begin
      if (settle_q == SETTLE_LAST) begin
        // Index wraps to 0 after the last vector, ready for the next sweep.
        settle_d = '0;
        idx_d    = idx_q + 1'b1;
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      settle_q <= '0;
    end else begin
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweep engine: drives every input vector to the CUT, samples its
// response, builds the measured truth table and counts mismatches against a latched golden table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_sweeper_if.slave bus
);

  localparam int TW = tw_of(N_IN);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || SETTLE < SETTLE_MIN) begin : g_param_check
    $error("truth_table_sweeper: N_IN must be 1..8 and SETTLE >= 1");
  end

  state_e          state_q, state_d;
  logic [N_IN-1:0] cut_in_q, cut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [TW-1:0]   table_q, table_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic [N_IN:0]   mcnt_q, mcnt_d;

  logic            cnt_clear, cnt_enable;
  logic            sample, last;
  logic [N_IN-1:0] idx;
  logic            miss;

  truth_table_sweeper_sweep_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_sweep_counter (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (cnt_clear),
    .enable_i        (cnt_enable),
    .idx_o           (idx),
    .sample_strobe_o (sample),
    .last_o          (last)
  );

  assign miss = bus.cut_out ^ exp_q[idx];

  // NOTE: every output of this block gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    state_d    = state_q;
    cut_in_d   = cut_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    table_d    = table_q;
    exp_d      = exp_q;
    mcnt_d     = mcnt_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state_q)
      IDLE: begin
        cut_in_d = '0;
        if (bus.start) begin
          exp_d     = bus.expected;
          table_d   = '0;
          mcnt_d    = '0;
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        cnt_enable = 1'b1;
        if (sample) begin
          table_d[idx] = bus.cut_out;
          mcnt_d       = mcnt_q + {{N_IN{1'b0}}, miss};
          if (last) begin
            // pass must include the final bit, so it is derived from the updated count.
            done_d   = 1'b1;
            busy_d   = 1'b0;
            pass_d   = (mcnt_d == '0);
            cut_in_d = '0;
            state_d  = IDLE;
          end else begin
            cut_in_d = idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      table_q  <= '0;
      // NOTE: the golden-table latch is reset as well, so no X can reach the comparator after reset.
      exp_q    <= '0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cut_in_q <= cut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      table_q  <= table_d;
      exp_q    <= exp_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign bus.cut_in       = cut_in_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with SETTLE=1 and a direct CUT, one
// with SETTLE=3 and a CUT whose response lags its input by two cycles.
module tb_truth_table_sweeper;

  localparam int N_IN  = 3;
  localparam int TW    = 8;
  localparam int SET_A = 1;
  localparam int SET_B = 3;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [1:0]    start_v;
  logic [TW-1:0] exp_v   [2];
  logic [TW-1:0] cut_tbl [2];
  logic          d1, d2;

  truth_table_sweeper_if #(.N_IN(N_IN)) bus0 ();
  truth_table_sweeper_if #(.N_IN(N_IN)) bus1 ();

  // CUTs are modelled as lookup tables indexed by the driven vector.
  assign bus0.start    = start_v[0];
  assign bus0.expected = exp_v[0];
  assign bus0.cut_out  = cut_tbl[0][bus0.cut_in];
  assign bus1.start    = start_v[1];
  assign bus1.expected = exp_v[1];
  assign bus1.cut_out  = d2;

  always @(posedge clk) begin
    d1 <= cut_tbl[1][bus1.cut_in];
    d2 <= d1;
  end

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SET_A)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SET_B)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]      busy_w, done_w, pass_w;
  logic [N_IN-1:0] cut_in_w [2];
  logic [TW-1:0]   table_w  [2];
  logic [N_IN:0]   mcnt_w   [2];

  assign busy_w      = {bus1.busy, bus0.busy};
  assign done_w      = {bus1.done, bus0.done};
  assign pass_w      = {bus1.pass, bus0.pass};
  assign cut_in_w[0] = bus0.cut_in;
  assign cut_in_w[1] = bus1.cut_in;
  assign table_w[0]  = bus0.table_out;
  assign table_w[1]  = bus1.table_out;
  assign mcnt_w[0]   = bus0.mismatch_cnt;
  assign mcnt_w[1]   = bus1.mismatch_cnt;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference CUT f = ~(A&B) | (B&C), vector index bits {A,B,C} with A as MSB.
  function automatic logic [TW-1:0] ref_cut();
    logic [TW-1:0] t;
    for (int i = 0; i < TW; i++) begin
      int a, b, c;
      a = (i >> 2) & 1;
      b = (i >> 1) & 1;
      c = i & 1;
      t[i] = ((a & b) == 0) || ((b & c) == 1);
    end
    return t;
  endfunction

  // One full sweep on instance d, checked cycle by cycle from the timing rules.
  task automatic do_sweep(input int d, input logic [TW-1:0] exp_t, input logic [TW-1:0] cut_t,
                          input string name, input int chg_at, input bit poke);
    int            settle;
    int            len;
    int            want_mm;
    logic [4:0]    obs, want;
    settle  = (d == 0) ? SET_A : SET_B;
    len     = TW * settle;
    want_mm = $countones(cut_t ^ exp_t);
    cut_tbl[d] = cut_t;
    exp_v[d]   = exp_t;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    for (int c = 0; c <= len; c++) begin
      if (c > 0) begin
        if (c == chg_at) exp_v[d] = ~exp_t;
        if (poke) start_v[d] = (c >= 2 && c <= 4);
        @(posedge clk); #1;
      end
      obs = {busy_w[d], done_w[d], cut_in_w[d]};
      if (c < len) want = {1'b1, 1'b0, 3'(c / settle)};
      else         want = {1'b0, 1'b1, 3'd0};
      total++;
      if (obs !== want) $display("FAIL %s cyc%0d {busy,done,cut_in}: got %b want %b", name, c, obs, want);
      else passed++;
    end
    start_v[d] = 1'b0;
    total++;
    if (table_w[d] !== cut_t) $display("FAIL %s table_out: got %h want %h", name, table_w[d], cut_t);
    else passed++;
    total++;
    if (mcnt_w[d] !== 4'(want_mm)) $display("FAIL %s mismatch_cnt: got %0d want %0d", name, mcnt_w[d], want_mm);
    else passed++;
    total++;
    if (pass_w[d] !== (want_mm == 0)) $display("FAIL %s pass: got %b want %b", name, pass_w[d], want_mm == 0);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({busy_w[d], done_w[d], table_w[d]} !== {2'b00, cut_t})
      $display("FAIL %s post-done hold: got %b/%b/%h want 0/0/%h", name, busy_w[d], done_w[d], table_w[d], cut_t);
    else passed++;
  endtask

  task automatic test_reset();
    start_v = '0;
    exp_v[0] = '0; exp_v[1] = '0;
    cut_tbl[0] = '0; cut_tbl[1] = '0;
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy_w[d], done_w[d], pass_w[d], cut_in_w[d], table_w[d], mcnt_w[d]} !== '0)
        $display("FAIL reset_async dut%0d: got %b/%b/%b/%h/%h/%0d want all 0", d, busy_w[d], done_w[d],
                 pass_w[d], cut_in_w[d], table_w[d], mcnt_w[d]);
      else passed++;
    end
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      total++;
      if ({busy_w, done_w, cut_in_w[0], cut_in_w[1]} !== '0)
        $display("FAIL idle cyc%0d: got busy=%b done=%b cut_in=%0d/%0d want 0", c, busy_w, done_w,
                 cut_in_w[0], cut_in_w[1]);
      else passed++;
    end
  endtask

  task automatic test_nominal();
    do_sweep(0, 8'hBF, ref_cut(), "nominal", -1, 1'b0);
  endtask

  task automatic test_fault();
    do_sweep(0, 8'hFF, ref_cut(), "fault_exp_ff", -1, 1'b0);
    do_sweep(0, 8'hBF, 8'h00, "fault_stuck0", -1, 1'b0);
  endtask

  task automatic test_settle();
    do_sweep(1, 8'hBF, ref_cut(), "settle3_delayed", -1, 1'b0);
    do_sweep(1, 8'hBF, 8'h00, "settle3_stuck0", -1, 1'b0);
  endtask

  task automatic test_start_handling();
    do_sweep(0, 8'hBF, ref_cut(), "start_poke", -1, 1'b1);
    do_sweep(0, 8'h5A, 8'h3C, "exp_change", 3, 1'b0);
    do_sweep(1, 8'hC3, 8'hC3, "exp_change_s3", 10, 1'b1);
  endtask

  task automatic test_back_to_back();
    int            p;
    int            phase;
    logic [TW-1:0] cur_cut, cur_exp;
    logic [4:0]    obs, want;
    p = TW * SET_A + 1;
    cur_cut = 8'($urandom);
    cur_exp = 8'($urandom);
    cut_tbl[0] = cur_cut;
    exp_v[0]   = cur_exp;
    start_v[0] = 1'b1;
    for (int c = 0; c < 3 * p; c++) begin
      @(posedge clk); #1;
      phase = c % p;
      obs = {busy_w[0], done_w[0], cut_in_w[0]};
      if (phase == 0)       want = {1'b1, 1'b0, 3'd0};
      else if (phase < TW)  want = {1'b1, 1'b0, 3'(phase)};
      else                  want = {1'b0, 1'b1, 3'd0};
      total++;
      if (obs !== want) $display("FAIL b2b cyc%0d {busy,done,cut_in}: got %b want %b", c, obs, want);
      else passed++;
      if (phase == TW) begin
        total++;
        if ({table_w[0], mcnt_w[0]} !== {cur_cut, 4'($countones(cur_cut ^ cur_exp))})
          $display("FAIL b2b result cyc%0d: got %h/%0d want %h/%0d", c, table_w[0], mcnt_w[0], cur_cut,
                   $countones(cur_cut ^ cur_exp));
        else passed++;
        cur_cut = 8'($urandom);
        cur_exp = 8'($urandom);
        cut_tbl[0] = cur_cut;
        exp_v[0]   = cur_exp;
      end
    end
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy_w[0], done_w[0]} !== 2'b00) $display("FAIL b2b stop: got busy=%b done=%b want 0/0", busy_w[0], done_w[0]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    cut_tbl[0] = ref_cut();
    exp_v[0]   = 8'hBF;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (cut_in_w[0] !== 3'd4) $display("FAIL reset_mid pre: got cut_in=%0d want 4", cut_in_w[0]);
    else passed++;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy_w[d], done_w[d], pass_w[d], cut_in_w[d], table_w[d], mcnt_w[d]} !== '0)
        $display("FAIL reset_mid async dut%0d: got %b/%b/%b/%h/%h/%0d want all 0", d, busy_w[d], done_w[d],
                 pass_w[d], cut_in_w[d], table_w[d], mcnt_w[d]);
      else passed++;
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst = 1'b0;
      total++;
      if ({busy_w, done_w} !== 4'b0000) $display("FAIL reset_mid no_done cyc%0d: got busy=%b done=%b want 0", c, busy_w, done_w);
      else passed++;
    end
    do_sweep(0, 8'hBF, ref_cut(), "after_reset", -1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int d;
      d = int'($urandom_range(0, 1));
      do_sweep(d, 8'($urandom), 8'($urandom), $sformatf("random%0d_dut%0d", k, d),
               int'($urandom_range(1, 6)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fault();
    test_settle();
    test_start_handling();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
